ultrasonic_scan_sched: RTL
==========================

# ultrasonic_scan_sched

Round-robin scheduler that shares one trigger/echo timing engine across four HC-SR04 ultrasonic sensors. It fires each sensor's trigger in turn, times that sensor's echo in microseconds, converts the echo width to centimetres, and stores a per-channel distance with a valid flag. It sits between the board's sensor pins and the display/PWM logic, and replaces per-sensor free-running controllers so that the sensors never fire at the same time.

## Interface
- `CLK_PER_US`, default 100: system clocks per 1 µs tick (100 MHz system clock).
- `TRIG_US`, default 10: trigger pulse width, in µs.
- `TIMEOUT_US`, default 25000: abort limit for both the echo wait and the echo width, in µs.
- `GAP_US`, default 60000: quiet time after each channel's measurement, in µs.
- `clk` input 1: system clock; every register is clocked on its rising edge.
- `reset_p` input 1: reset is synchronous and active-high.
- `enable` input 1: when high, scanning runs.
- `echo` input 4: raw echo pins, one per channel, asynchronous to `clk`.
- `trig` output 4: trigger pins; at most one bit is high at any time.
- `distance` output 36: packed distances in cm; channel k is bits [9k+8:9k].
- `valid` output 4: high when the channel's last measurement completed without timeout.
- `cur_ch` output 2: channel currently being serviced.
- `meas_done` output 1: one-clock pulse when a channel result is written.

## Operation
- **Echo synchronisation:** each `echo` bit passes through a 2-flop synchroniser, followed by a registered copy used for edge detection. Only the bit selected by `cur_ch` is examined.
- **µs tick:**
  - A prescaler counts from 0 to CLK_PER_US-1 and issues a one-clock tick when it wraps.
  - The prescaler resets to 0 on every state entry, so every timed interval is measured from a clean tick boundary.
- **State machine (registered):**
  - IDLE: all `trig` bits are 0. Move to TRIG when `enable`=1.
  - TRIG: `trig[cur_ch]`=1. After TRIG_US ticks, drive it back to 0 and move to WAIT_HI.
  - WAIT_HI:
    - A rising edge on the synchronised echo moves to MEASURE and clears the cm counter and the 0..57 µs sub-counter.
    - If the µs counter reaches TIMEOUT_US first, record a timeout and move to GAP.
  - MEASURE:
    - On each tick, the sub-counter increments. When it wraps at 57, the cm counter increments.
    - A falling edge moves to GAP and writes `distance[cur_ch]` = cm count (floor(width_µs/58)) and `valid[cur_ch]`=1.
    - Reaching TIMEOUT_US of echo-high time counts as a timeout.
  - GAP:
    - Wait GAP_US ticks, then increment `cur_ch` modulo 4, wrapping 3→0.
    - Go to TRIG if `enable`=1, otherwise go to IDLE.
- **Timeout result:** `distance[cur_ch]`=9'h1FF and `valid[cur_ch]`=0.
- **Width rule:** the cm counter is 9 bits. With the default timeout the maximum count is 431, so it never wraps. With larger TIMEOUT_US it saturates at 511.
- **Enable deassert:** lowering `enable` mid-cycle does not abort the current channel. TRIG, WAIT_HI and MEASURE complete and the result is written. The stop takes effect only at the end of GAP.
- **Stray edges:** echo edges on non-selected channels, or in TRIG, GAP or IDLE, are ignored. An echo that is already high on entry to WAIT_HI is not a rising edge; the channel waits for a real rising edge or times out.

## Timing
- **Reset values:**
  - `trig`=0, `distance`=all zeros, `valid`=0, `cur_ch`=0, `meas_done`=0.
  - State is IDLE and all counters are 0.
- **Trigger:** `trig[cur_ch]` rises on the clock after TRIG is entered and is high for exactly TRIG_US×CLK_PER_US clocks.
- **Result latency:**
  - `distance`, `valid` and `meas_done` update together, 4 clocks after the raw echo falls (2 sync + 1 edge register + 1 output register).
  - For timeouts they update on the clock after the limit tick.
- **Result hold:** `meas_done` is high for exactly one clock. `distance` and `valid` hold until that channel is next written.
- **Synchronous reset mid-operation:** takes effect on the next clock edge. `trig` drops immediately, results are cleared, and the scan restarts from channel 0.

## Test plan
- Bench uses CLK_PER_US=2, GAP_US=20, TIMEOUT_US=1000.
- **Basic measurement:** `enable`=1, echo0 goes high 5 µs after trig0 falls and stays high 580 µs → `trig[0]` is high 10 µs (20 clocks), `distance[8:0]`=10, `valid[0]`=1, one `meas_done` pulse, then `cur_ch`=1.
- **Round robin with per-channel widths:** echo widths 116/1740/57/0 µs on channels 0..3 (channel 3 never rises) → distances 2/30/0/511, `valid`=4'b0111, trig order 0,1,2,3,0.
- **Echo-high timeout:** echo1 held high 2000 µs → timeout at 1000 µs, `distance[17:9]`=511, `valid[1]`=0; the next channel proceeds normally.
- **Enable drop mid-measure:** drop `enable` during MEASURE on channel 2 → channel 2 result is written, state goes to IDLE after GAP, `cur_ch`=3, no further `trig`.
- **Reset and ignored edges:** assert `reset_p` one clock while `trig[0]` is high → next clock `trig`=0, `valid`=0, `cur_ch`=0. Toggling echo2 while channel 0 is serviced has no effect on any output.

Source files
------------

// File: rtl/ultrasonic_scan_sched.sv
// Round-robin trigger/echo scheduler for four HC-SR04 sensors sharing one timing engine.
// Each channel is triggered in turn, its echo is timed in 1 us ticks, and the result is stored in cm.
module ultrasonic_scan_sched #(
    parameter int CLK_PER_US = 100,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 25000,
    parameter int GAP_US     = 60000
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        enable,
    input  logic [3:0]  echo,
    output logic [3:0]  trig,
    output logic [35:0] distance,
    output logic [3:0]  valid,
    output logic [1:0]  cur_ch,
    output logic        meas_done
);
    localparam int MAX_US = (TIMEOUT_US > GAP_US)
                          ? ((TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US)
                          : ((GAP_US > TRIG_US) ? GAP_US : TRIG_US);
    localparam int US_W = $clog2(MAX_US + 1);
    localparam int PS_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_HI,
        S_MEASURE,
        S_GAP
    } state_t;

    state_t          state, state_next;
    logic [3:0]      echo_s1, echo_s2, echo_d;
    logic            rise_q, fall_q;
    logic [PS_W-1:0] presc;
    logic [US_W-1:0] us_cnt, us_inc;
    logic [5:0]      sub_cnt;
    logic [8:0]      cm_cnt, cm_next;
    logic            tick;
    logic            wr_ok, wr_to, advance;

    assign tick   = (presc == PS_W'(CLK_PER_US - 1));
    assign us_inc = us_cnt + US_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset_p) state <= S_IDLE;
        else         state <= state_next;
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        wr_ok      = 1'b0;
        wr_to      = 1'b0;
        advance    = 1'b0;
        case (state)
            S_IDLE:    if (enable) state_next = S_TRIG;
            S_TRIG:    if (tick && us_inc == US_W'(TRIG_US)) state_next = S_WAIT_HI;
            S_WAIT_HI: begin
                if (rise_q) begin
                    state_next = S_MEASURE;
                end else if (tick && us_inc == US_W'(TIMEOUT_US)) begin
                    wr_to      = 1'b1;
                    state_next = S_GAP;
                end
            end
            S_MEASURE: begin
                // An echo that lasts the full limit is a timeout even if it falls on that same tick.
                if (tick && us_inc == US_W'(TIMEOUT_US)) begin
                    wr_to      = 1'b1;
                    state_next = S_GAP;
                end else if (fall_q) begin
                    wr_ok      = 1'b1;
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (tick && us_inc == US_W'(GAP_US)) begin
                    advance    = 1'b1;
                    state_next = enable ? S_TRIG : S_IDLE;
                end
            end
            default:   state_next = S_IDLE;
        endcase
    end

    // Edges are qualified by state when registered, so stray edges outside the listening states vanish.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            echo_s1 <= '0;
            echo_s2 <= '0;
            echo_d  <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            echo_s1 <= echo;
            echo_s2 <= echo_s1;
            echo_d  <= echo_s2;
            rise_q  <= (state == S_WAIT_HI) &&  echo_s2[cur_ch] && !echo_d[cur_ch];
            fall_q  <= (state == S_MEASURE) && !echo_s2[cur_ch] &&  echo_d[cur_ch];
        end
    end

    always_comb begin
        cm_next = cm_cnt;
        if (tick && sub_cnt == 6'd57 && cm_cnt != 9'h1FF) cm_next = cm_cnt + 9'd1;
    end

    // All interval counters restart on every state change so each interval begins on a tick boundary.
    always_ff @(posedge clk) begin
        if (reset_p || state_next != state) begin
            presc   <= '0;
            us_cnt  <= '0;
            sub_cnt <= '0;
            cm_cnt  <= '0;
        end else if (state != S_IDLE) begin
            presc  <= tick ? '0 : presc + PS_W'(1);
            cm_cnt <= cm_next;
            if (tick) begin
                us_cnt  <= us_inc;
                sub_cnt <= (sub_cnt == 6'd57) ? 6'd0 : sub_cnt + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            trig      <= '0;
            distance  <= '0;
            valid     <= '0;
            cur_ch    <= '0;
            meas_done <= 1'b0;
        end else begin
            trig      <= (state == S_TRIG) ? (4'b0001 << cur_ch) : 4'b0000;
            meas_done <= wr_ok || wr_to;
            if (wr_ok) begin
                distance[9*cur_ch +: 9] <= cm_next;
                valid[cur_ch]           <= 1'b1;
            end else if (wr_to) begin
                distance[9*cur_ch +: 9] <= 9'h1FF;
                valid[cur_ch]           <= 1'b0;
            end
            if (advance) cur_ch <= cur_ch + 2'd1;
        end
    end

endmodule
